// File: rtl/barrel_shifter_pkg.sv
// Shared types for the pipelined barrel shifter: operation encoding and the
// per-stage pipeline record, sized for the largest supported N (6).
`timescale 1ns/1ps
package barrel_shifter_pkg;

  localparam int N_MAX = 6;
  localparam int W_MAX = 1 << N_MAX;

  typedef enum logic [1:0] {
    MODE_ROL = 2'd0,
    MODE_ROR = 2'd1,
    MODE_LSL = 2'd2,
    MODE_LSR = 2'd3
  } mode_t;

  // Narrower instances keep the unused upper data/amt bits at zero.
  typedef struct packed {
    logic [W_MAX-1:0] data;
    logic [N_MAX-1:0] amt;
    mode_t            mode;
    logic             valid;
  } stage_rec_t;

  function automatic logic [W_MAX-1:0] width_mask(input int w);
    logic [W_MAX-1:0] one;
    one = {{(W_MAX-1){1'b0}}, 1'b1};
    width_mask = (one << w) - one;
  endfunction

endpackage

// File: rtl/pipelined_barrel_shifter_shift_stage.sv
// One pipeline stage: conditionally shifts/rotates by 2**K inside a W-bit
// window, then registers the record and a zero flag when the pipe advances.
`timescale 1ns/1ps
module shift_stage
  import barrel_shifter_pkg::*;
#(
  parameter int K = 0,
  parameter int W = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       adv,
  input  stage_rec_t in_rec,
  output stage_rec_t out_rec,
  output logic       out_zero
);

  localparam int S = 1 << K;
  localparam logic [W_MAX-1:0] MASK = width_mask(W);

  stage_rec_t next_s;

  // Apply this stage's 2**K step when its amount bit is set.
  always_comb begin
    next_s = in_rec;
    if (in_rec.amt[K]) begin
      case (in_rec.mode)
        MODE_ROL: next_s.data = ((in_rec.data << S) | (in_rec.data >> (W - S))) & MASK;
        MODE_ROR: next_s.data = ((in_rec.data >> S) | (in_rec.data << (W - S))) & MASK;
        MODE_LSL: next_s.data = (in_rec.data << S) & MASK;
        MODE_LSR: next_s.data = in_rec.data >> S;
        default:  next_s.data = in_rec.data;
      endcase
    end else begin
      next_s.data = in_rec.data;
    end
  end

  // Stage register; data is left uncleared on reset, only valid/zero are.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_rec.valid <= 1'b0;
      out_zero      <= 1'b0;
    end else if (adv) begin
      out_rec  <= next_s;
      out_zero <= (next_s.data == {W_MAX{1'b0}});
    end
  end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// N-stage pipelined barrel shifter (ROL/ROR/LSL/LSR) with a global
// advance enable driven by the output handshake.
`timescale 1ns/1ps
module pipelined_barrel_shifter
  import barrel_shifter_pkg::*;
#(
  parameter int N = 4,
  localparam int W = 1 << N
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic [N-1:0] in_amt,
  input  logic [1:0]   in_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_zero
);

  logic         adv;
  stage_rec_t   head;
  stage_rec_t   stage_out [N];
  logic [N-1:0] stage_zero;
  logic         unused_tail;

  assign adv = !out_valid || out_ready;
  // Pipeline is being emptied during reset, so the input side reads as ready.
  assign in_ready = adv || reset;

  // Build the stage-0 record; no accepted beat means a bubble.
  always_comb begin
    head.data  = W_MAX'(in_data);
    head.amt   = N_MAX'(in_amt);
    head.mode  = mode_t'(in_mode);
    head.valid = in_valid && adv && !reset;
  end

  for (genvar k = 0; k < N; k++) begin : g_stage
    stage_rec_t stage_in_s;
    if (k == 0) begin : g_first
      assign stage_in_s = head;
    end else begin : g_rest
      assign stage_in_s = stage_out[k-1];
    end

    shift_stage #(
      .K(k),
      .W(W)
    ) u_stage (
      .clk     (clk),
      .reset   (reset),
      .adv     (adv),
      .in_rec  (stage_in_s),
      .out_rec (stage_out[k]),
      .out_zero(stage_zero[k])
    );
  end

  assign out_valid = stage_out[N-1].valid;
  assign out_data  = stage_out[N-1].data[W-1:0];
  assign out_zero  = stage_zero[N-1];

  assign unused_tail = ^{stage_out[N-1].data, stage_out[N-1].amt,
                         stage_out[N-1].mode, stage_zero};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Bench for pipelined_barrel_shifter (N=4): directed vectors plus a bit-level
// reference model and a per-cycle scoreboard on the output handshake.
`timescale 1ns/1ps
module tb_pipelined_barrel_shifter;

  localparam int N = 4;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [N-1:0] in_amt;
  logic [1:0]   in_mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_zero;

  int total = 0;
  int bad = 0;
  int accepted = 0;
  int run_cur = 0;
  int last_run = 0;
  logic [W-1:0] exp_q[$];
  logic         held = 1'b0;
  logic [W-1:0] held_data;
  logic         held_zero;

  pipelined_barrel_shifter #(.N(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_amt   (in_amt),
    .in_mode  (in_mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_zero (out_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: place every input bit at its destination index.
  function automatic logic [15:0] ref_op(input logic [15:0] d, input int a, input int m);
    logic [15:0] r;
    r = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      case (m)
        0: r[(i + a) % 16] = d[i];
        1: r[(i + 16 - a) % 16] = d[i];
        2: if (i + a < 16) r[i + a] = d[i];
        default: if (i >= a) r[i - a] = d[i];
      endcase
    end
    return r;
  endfunction

  // Scoreboard, hold and handshake checks, sampled mid-cycle.
  always @(negedge clk) begin : compare
    logic [W-1:0] e;
    if (reset) begin
      check("rst_in_ready", in_ready, 1'b1);
      exp_q.delete();
      held = 1'b0;
      run_cur = 0;
    end else begin
      if (held) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_data", out_data, held_data);
        check("hold_zero", out_zero, held_zero);
      end
      check("in_ready", in_ready, !out_valid || out_ready);
      if (out_valid) begin
        check("zero_flag", out_zero, out_data == 16'h0000);
        run_cur++;
      end else begin
        if (run_cur > 0) last_run = run_cur;
        run_cur = 0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_extra_beat", out_data, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("sb_data", out_data, e);
        end
      end
      held = out_valid && !out_ready;
      held_data = out_data;
      held_zero = out_zero;
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_op(in_data, int'(in_amt), int'(in_mode)));
        accepted++;
      end
    end
  end

  task automatic push_beat(input logic [15:0] d, input int a, input int m);
    logic ok;
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = 4'(a);
    in_mode  = 2'(m);
    ok = 1'b0;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready && !reset;
      @(posedge clk);
      #1;
    end
    if (!ok) check("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_check(input string name, input logic [15:0] d, input int a,
                            input int m, input logic [15:0] exp, input logic expz);
    int lat;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = d;
    in_amt    = 4'(a);
    in_mode   = 2'(m);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({name, "_latency"}, lat, 4);
    check({name, "_data"}, out_data, exp);
    check({name, "_zero"}, out_zero, expz);
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: run did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = 16'h0000;
    in_amt = 4'd0;
    in_mode = 2'd0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_out_zero", out_zero, 1'b0);
    check("reset_in_ready", in_ready, 1'b1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset_in_ready", in_ready, 1'b1);

    // Pin the model with hand-computed values.
    check("model_rol", ref_op(16'h8001, 1, 0), 16'h0003);
    check("model_ror", ref_op(16'h8001, 1, 1), 16'hC000);
    check("model_lsl", ref_op(16'h0001, 15, 2), 16'h8000);
    check("model_lsr", ref_op(16'h8000, 15, 3), 16'h0001);
    check("model_rol4", ref_op(16'h1234, 4, 0), 16'h2341);

    send_check("rol_8001_1", 16'h8001, 1, 0, 16'h0003, 1'b0);
    send_check("ror_8001_1", 16'h8001, 1, 1, 16'hC000, 1'b0);
    send_check("lsl_0001_15", 16'h0001, 15, 2, 16'h8000, 1'b0);
    send_check("lsr_8000_15", 16'h8000, 15, 3, 16'h0001, 1'b0);
    send_check("lsr_00ff_8", 16'h00FF, 8, 3, 16'h0000, 1'b1);
    send_check("ror_1234_4", 16'h1234, 4, 1, 16'h4123, 1'b0);
    send_check("lsl_beef_0", 16'hBEEF, 0, 2, 16'hBEEF, 1'b0);
    send_check("ror_beef_0", 16'hBEEF, 0, 1, 16'hBEEF, 1'b0);

    // Back-to-back 16 beats.
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) push_beat(16'h1234, i, 0);
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("b2b_run_len", last_run, 16);
    check("b2b_drained", exp_q.size(), 0);

    // Fill with out_ready low, stall 5 cycles, then resume.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_beat(16'(32'h1111 * (i + 1)), (3 * i) % 16, i % 4);
    in_valid = 1'b1;
    in_data  = 16'h5555;
    in_amt   = 4'd12;
    in_mode  = 2'd0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("stall_in_ready", in_ready, 1'b0);
      check("stall_out_valid", out_valid, 1'b1);
      check("stall_out_data", out_data, ref_op(16'h1111, 0, 0));
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    for (int i = 4; i < 8; i++) push_beat(16'(32'h1111 * (i + 1)), (3 * i) % 16, i % 4);
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("stall_drained", exp_q.size(), 0);

    // Reset with 3 beats in flight; in_valid held during reset.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) push_beat(16'hF00F, i + 1, 0);
    reset = 1'b1;
    in_valid = 1'b1;
    in_data = 16'hABCD;
    @(negedge clk);
    check("midrst_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_in_ready_after", in_ready, 1'b1);
    reset = 1'b0;
    in_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      check("midrst_no_stale", out_valid, 1'b0);
    end

    // Random traffic, random backpressure.
    begin
      int start;
      int cyc;
      start = accepted;
      cyc = 0;
      while (accepted < start + 10000 && cyc < 60000) begin
        in_valid  = ($urandom_range(0, 9) < 7);
        in_data   = 16'($urandom);
        in_amt    = 4'($urandom_range(0, 15));
        in_mode   = 2'($urandom_range(0, 3));
        out_ready = ($urandom_range(0, 9) < 6);
        @(posedge clk);
        #1;
        cyc++;
      end
      check("rand_beats", accepted - start, 10000);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("rand_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
